ifetch_resp: RTL and testbench
==============================

Name: ifetch_resp

Overview:
- Instruction-fetch responder on the far side of the program counter's fetch interface.
- Takes the current fetch address, runs a request/grant/response transaction to instruction memory, and returns the instruction word.
- Drives the 2-bit hold that freezes the program counter while a fetch is outstanding.
- Accepts the jump redirect and discards any in-flight response made stale by it.

Parameters:
- ADDR_W, 32, fetch address width.
- INST_W, 32, instruction width.
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT before the fetch is declared failed (1..255).
- NOP_INST, 32'h00000013, instruction substituted on reset, flush or timeout.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high (`RST).
- fetch_en_i  input  1  fetch permitted this cycle.
- pc_i  input  ADDR_W  fetch address from the program counter.
- jump_i  input  1  redirect; the outstanding fetch is stale.
- req_o  output  1  memory request valid.
- addr_o  output  ADDR_W  memory request address.
- gnt_i  input  1  memory accepted the request.
- rvalid_i  input  1  read data valid.
- rdata_i  input  INST_W  read data.
- inst_o  output  INST_W  fetched instruction.
- inst_valid_o  output  1  inst_o is new this cycle (1-cycle pulse).
- hold_o  output  2  2'b01 = hold the program counter, 2'b00 = release.
- err_o  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset (async, rst high), while asserted and until the first transition:
  - state IDLE, req_o 0, addr_o 0.
  - inst_o NOP_INST, inst_valid_o 0, hold_o 00, err_o 0.
  - timeout counter 0, flush flag 0.
- Reset mid-transaction abandons it; any later rvalid_i is ignored until a new request is granted.
- States: IDLE, REQ, WAIT.
- IDLE:
  - If fetch_en_i=1 and jump_i=0: latch addr_o<=pc_i, req_o<=1, go to REQ.
  - Else stay in IDLE.
- REQ:
  - req_o=1 and addr_o held stable until gnt_i=1.
  - On gnt_i=1: req_o<=0, counter<=0, go to WAIT.
  - jump_i=1 in REQ sets the flush flag; the request is not withdrawn.
- WAIT:
  - Counter increments each cycle.
  - jump_i=1 sets the flush flag.
  - On rvalid_i=1 with flush flag=0 and jump_i=0: next cycle inst_o<=rdata_i and inst_valid_o=1 for exactly one cycle; go to IDLE.
  - On rvalid_i=1 with flush flag=1, or with jump_i=1 in the same cycle: data discarded, inst_o<=NOP_INST, inst_valid_o stays 0, flush flag cleared, go to IDLE.
  - If the counter reaches TIMEOUT_CYC with no rvalid_i: err_o<=1 (sticky until rst), inst_o<=NOP_INST, inst_valid_o pulses 1, flush flag cleared, go to IDLE.
- hold_o (combinational from state):
  - 2'b01 in REQ and WAIT.
  - 2'b01 in IDLE when fetch_en_i=1 and jump_i=0.
  - 2'b00 otherwise.
  - 2'b00 in the cycle inst_valid_o=1.
- Latency with gnt_i in the first REQ cycle and rvalid_i in the first WAIT cycle: 3 cycles from fetch_en_i high to inst_valid_o high.
- rvalid_i in IDLE or REQ is ignored.
- Only one outstanding transaction at any time.
- inst_o holds its last value between pulses.

Test Plan:
- Reset then release:
  - Expected: inst_o=32'h00000013, hold_o=00, req_o=0, err_o=0.
  - With fetch_en_i=0 for 10 cycles: no req_o.
- Single fetch:
  - Stimulus: pc_i=32'h00000100, fetch_en_i=1, gnt_i=1 immediately, rvalid_i=1 with rdata_i=32'h00a00093 one cycle later.
  - Expected: addr_o=32'h100; inst_o=32'h00a00093 with inst_valid_o=1 at cycle 3; hold_o=01 in cycles 0-2.
- Grant stall:
  - Stimulus: gnt_i held 0 for 4 cycles while pc_i changes to 32'h104.
  - Expected: addr_o stays 32'h100 and req_o stays 1 until gnt_i.
- Flush:
  - Stimulus: jump_i=1 during WAIT, then rvalid_i with rdata_i=32'hdeadbeef.
  - Expected: inst_valid_o never pulses, inst_o=NOP, state back to IDLE; the next fetch of pc_i=32'h200 completes normally.
- Timeout:
  - Stimulus: TIMEOUT_CYC=4, no rvalid_i.
  - Expected: after 4 WAIT cycles err_o=1, inst_o=NOP with inst_valid_o=1; err_o stays 1 until rst.
- Async reset mid-WAIT:
  - Stimulus: rst pulse between clock edges.
  - Expected: outputs return to reset values immediately; a late rvalid_i is ignored.

Source files
------------

// File: rtl/ifetch_resp.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_resp
// Description : Instruction-fetch responder. Issues one request/grant/response
//               transaction per fetch, holds the program counter while a fetch
//               is outstanding, and drops responses made stale by a jump.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_resp #(
  parameter int                 ADDR_W      = 32,
  parameter int                 INST_W      = 32,
  parameter int                 TIMEOUT_CYC = 255,
  parameter logic [INST_W-1:0]  NOP_INST    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_i,
  output logic              req_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  input  logic [INST_W-1:0] rdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic [1:0]        hold_o,
  output logic              err_o
);

  localparam int               CNT_W        = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               flush, flush_nxt;
  logic               req_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [INST_W-1:0]  inst_nxt;
  logic               valid_nxt;
  logic               err_nxt;

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      flush        <= 1'b0;
      req_o        <= 1'b0;
      addr_o       <= '0;
      inst_o       <= NOP_INST;
      inst_valid_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      flush        <= flush_nxt;
      req_o        <= req_nxt;
      addr_o       <= addr_nxt;
      inst_o       <= inst_nxt;
      inst_valid_o <= valid_nxt;
      err_o        <= err_nxt;
    end
  end

  // Next-state and next-output decode for the fetch transaction
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    flush_nxt = flush;
    req_nxt   = req_o;
    addr_nxt  = addr_o;
    inst_nxt  = inst_o;
    valid_nxt = 1'b0;
    err_nxt   = err_o;
    case (state)
      IDLE: begin
        // While a fresh instruction is being presented the PC is released and
        // pc_i still shows the address just fetched, so do not refetch it.
        if (fetch_en_i && !jump_i && !inst_valid_o) begin
          addr_nxt  = pc_i;
          req_nxt   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // A jump cannot withdraw an issued request; remember to drop its data.
        if (jump_i) begin
          flush_nxt = 1'b1;
        end
        if (gnt_i) begin
          req_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (jump_i) begin
          flush_nxt = 1'b1;
        end
        if (rvalid_i) begin
          state_nxt = IDLE;
          flush_nxt = 1'b0;
          if (flush || jump_i) begin
            inst_nxt = NOP_INST;
          end else begin
            inst_nxt  = rdata_i;
            valid_nxt = 1'b1;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          // Memory never answered: present a NOP so the core can advance.
          err_nxt   = 1'b1;
          inst_nxt  = NOP_INST;
          valid_nxt = 1'b1;
          flush_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Freeze the PC while a fetch is pending or about to start
  always_comb begin
    hold_o = 2'b00;
    if (!inst_valid_o && ((state != IDLE) || (fetch_en_i && !jump_i))) begin
      hold_o = 2'b01;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_resp
// Description : Self-checking bench for ifetch_resp with a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_resp;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en_i;
  logic [31:0] pc_i;
  logic        jump_i;
  logic        req_o;
  logic [31:0] addr_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic [1:0]  hold_o;
  logic        err_o;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  ifetch_resp #(
    .ADDR_W      (32),
    .INST_W      (32),
    .TIMEOUT_CYC (4),
    .NOP_INST    (NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en_i   (fetch_en_i),
    .pc_i         (pc_i),
    .jump_i       (jump_i),
    .req_o        (req_o),
    .addr_o       (addr_o),
    .gnt_i        (gnt_i),
    .rvalid_i     (rvalid_i),
    .rdata_i      (rdata_i),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .hold_o       (hold_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then settle
  task automatic cyc(input logic fe, input logic [31:0] pc, input logic j,
                     input logic g, input logic rv, input logic [31:0] rd);
    @(negedge clk);
    fetch_en_i = fe;
    pc_i       = pc;
    jump_i     = j;
    gnt_i      = g;
    rvalid_i   = rv;
    rdata_i    = rd;
    #1;
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest expectation
  always begin
    @(posedge clk);
    #1;
    if (inst_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got inst %h err %b, required no pulse", inst_o, err_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_inst", inst_o, e.inst);
        chk("pulse_err", 32'(err_o), 32'(e.err));
      end
    end
  end

  // Normal fetch: grant in first REQ cycle, data in first WAIT cycle
  task automatic fetch_ok(input logic [31:0] pc, input logic [31:0] d);
    cyc(1, pc, 0, 0, 0, 32'h0);
    chk("hold_c0", 32'(hold_o), 32'h1);
    exp_q.push_back(exp_t'{inst: d, err: 1'b0});
    cyc(0, pc, 0, 1, 0, 32'h0);
    chk("req_c1", 32'(req_o), 32'h1);
    chk("addr_c1", addr_o, pc);
    chk("hold_c1", 32'(hold_o), 32'h1);
    cyc(0, pc, 0, 0, 1, d);
    chk("req_c2", 32'(req_o), 32'h0);
    chk("hold_c2", 32'(hold_o), 32'h1);
    cyc(0, pc, 0, 0, 0, 32'h0);
    chk("valid_c3", 32'(inst_valid_o), 32'h1);
    chk("hold_c3", 32'(hold_o), 32'h0);
    cyc(0, pc, 0, 0, 0, 32'h0);
    chk("valid_c4", 32'(inst_valid_o), 32'h0);
    chk("inst_hold", inst_o, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    fetch_en_i = 1'b0; pc_i = '0; jump_i = 1'b0;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;

    // Reset state
    @(negedge clk);
    chk("rst_inst", inst_o, NOP);
    chk("rst_hold", 32'(hold_o), 32'h0);
    chk("rst_req", 32'(req_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_addr", addr_o, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 32'h100, 0, 0, 0, 32'h0);
      chk("idle_req", 32'(req_o), 32'h0);
    end

    // Single fetch, 3-cycle latency
    fetch_ok(32'h100, 32'h00a00093);

    // Grant stall with pc_i moving underneath
    cyc(1, 32'h100, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 32'h104, 0, 0, 0, 32'h0);
      chk("stall_req", 32'(req_o), 32'h1);
      chk("stall_addr", addr_o, 32'h100);
    end
    cyc(1, 32'h104, 0, 1, 0, 32'h0);
    chk("stall_req_gnt", 32'(req_o), 32'h1);
    exp_q.push_back(exp_t'{inst: 32'h00100113, err: 1'b0});
    cyc(0, 32'h104, 0, 0, 1, 32'h00100113);
    chk("stall_req_wait", 32'(req_o), 32'h0);
    cyc(0, 32'h104, 0, 0, 0, 32'h0);
    chk("stall_valid", 32'(inst_valid_o), 32'h1);
    cyc(0, 32'h104, 0, 0, 0, 32'h0);

    // Jump during WAIT, stale data arrives later
    cyc(1, 32'h180, 0, 0, 0, 32'h0);
    cyc(0, 32'h180, 0, 1, 0, 32'h0);
    cyc(0, 32'h180, 1, 0, 0, 32'h0);
    cyc(0, 32'h180, 0, 0, 1, 32'hdeadbeef);
    cyc(0, 32'h180, 0, 0, 0, 32'h0);
    chk("flush_valid", 32'(inst_valid_o), 32'h0);
    chk("flush_inst", inst_o, NOP);
    chk("flush_hold", 32'(hold_o), 32'h0);
    fetch_ok(32'h200, 32'h00200213);

    // Jump in the same cycle as rvalid
    cyc(1, 32'h220, 0, 0, 0, 32'h0);
    cyc(0, 32'h220, 0, 1, 0, 32'h0);
    cyc(0, 32'h220, 1, 0, 1, 32'h12345678);
    cyc(0, 32'h220, 0, 0, 0, 32'h0);
    chk("jmp_rv_valid", 32'(inst_valid_o), 32'h0);
    chk("jmp_rv_inst", inst_o, NOP);
    fetch_ok(32'h204, 32'h00300193);

    // Jump during REQ, before the grant
    cyc(1, 32'h240, 0, 0, 0, 32'h0);
    cyc(0, 32'h240, 1, 0, 0, 32'h0);
    chk("req_flush_req", 32'(req_o), 32'h1);
    cyc(0, 32'h240, 0, 1, 0, 32'h0);
    cyc(0, 32'h240, 0, 0, 1, 32'h11111111);
    cyc(0, 32'h240, 0, 0, 0, 32'h0);
    chk("req_flush_valid", 32'(inst_valid_o), 32'h0);
    chk("req_flush_inst", inst_o, NOP);
    fetch_ok(32'h208, 32'h00400093);

    // Timeout after four WAIT cycles
    cyc(1, 32'h300, 0, 0, 0, 32'h0);
    cyc(0, 32'h300, 0, 1, 0, 32'h0);
    exp_q.push_back(exp_t'{inst: NOP, err: 1'b1});
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h300, 0, 0, 0, 32'h0);
      chk("to_wait_err", 32'(err_o), 32'h0);
      chk("to_wait_valid", 32'(inst_valid_o), 32'h0);
      chk("to_wait_hold", 32'(hold_o), 32'h1);
    end
    cyc(0, 32'h300, 0, 0, 0, 32'h0);
    chk("to_err", 32'(err_o), 32'h1);
    chk("to_valid", 32'(inst_valid_o), 32'h1);
    chk("to_inst", inst_o, NOP);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h300, 0, 0, 0, 32'h0);
      chk("to_sticky", 32'(err_o), 32'h1);
    end

    // Asynchronous reset in the middle of WAIT
    cyc(1, 32'h400, 0, 0, 0, 32'h0);
    cyc(0, 32'h400, 0, 1, 0, 32'h0);
    cyc(0, 32'h400, 0, 0, 0, 32'h0);
    chk("pre_rst_hold", 32'(hold_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_err", 32'(err_o), 32'h0);
    chk("arst_req", 32'(req_o), 32'h0);
    chk("arst_addr", addr_o, 32'h0);
    chk("arst_hold", 32'(hold_o), 32'h0);
    chk("arst_inst", inst_o, NOP);
    #1;
    rst = 1'b0;
    cyc(0, 32'h400, 0, 0, 1, 32'hcafef00d);
    cyc(0, 32'h400, 0, 0, 0, 32'h0);
    chk("late_rv_valid", 32'(inst_valid_o), 32'h0);
    chk("late_rv_inst", inst_o, NOP);
    fetch_ok(32'h500, 32'h00500293);

    repeat (3) cyc(0, 32'h0, 0, 0, 0, 32'h0);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
